// File: rtl/rom_lookup_arbiter_if.sv
// rom_lookup_arbiter_if: one requester's valid/ready request and response channels.
interface rom_lookup_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_data);
  modport slave (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/rom_lookup_arbiter.sv
// rom_lookup_arbiter: round-robin sharing of one synchronous ROM between two requesters.
module rom_lookup_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  rom_lookup_arbiter_if.slave p0,
  rom_lookup_arbiter_if.slave p1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);
  localparam int CW = $clog2(ROM_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state;
  logic          rr_ptr;
  logic          owner;
  logic          gnt;
  logic [CW-1:0] cnt;
  assign gnt          = (p0.req_valid && p1.req_valid) ? rr_ptr : p1.req_valid;
  // ready is gated by rst_n so no handshake is advertised while reset is held
  assign p0.req_ready = rst_n && state == IDLE && p0.req_valid && !gnt;
  assign p1.req_ready = rst_n && state == IDLE && p1.req_valid && gnt;
  assign busy         = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      owner        <= 1'b0;
      cnt          <= '0;
      rom_addr     <= '0;
      p0.rsp_valid <= 1'b0;
      p1.rsp_valid <= 1'b0;
      p0.rsp_data  <= '0;
      p1.rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: if (p0.req_ready || p1.req_ready) begin
          rom_addr <= gnt ? p1.req_addr : p0.req_addr;
          owner    <= gnt;
          cnt      <= CW'(ROM_LAT);
          state    <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          if (owner) begin
            p1.rsp_data  <= rom_data;
            p1.rsp_valid <= 1'b1;
          end else begin
            p0.rsp_data  <= rom_data;
            p0.rsp_valid <= 1'b1;
          end
          state <= RESP;
        end else cnt <= cnt - 1'b1;
        RESP: if (owner ? p1.rsp_ready : p0.rsp_ready) begin
          p0.rsp_valid <= 1'b0;
          p1.rsp_valid <= 1'b0;
          rr_ptr       <= ~owner;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_lookup_arbiter.sv
// tb_rom_lookup_arbiter: scoreboard bench with a spec-level arbitration and ROM model.
module tb_rom_lookup_arbiter;
  localparam int LAT = 1;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int errors = 0;
  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction
  function automatic logic [7:0] rom_val(int i);
    return 8'(32 + (i * 9) / 5);
  endfunction
  rom_lookup_arbiter_if a0 ();
  rom_lookup_arbiter_if a1 ();
  rom_lookup_arbiter_if b0 ();
  rom_lookup_arbiter_if b1 ();
  logic [1:0] v = 0;
  logic [1:0] rrdy = 2'b11;
  logic [3:0] ad [2];
  logic [1:0] qrdy;
  logic [1:0] svld;
  logic [7:0] sdat [2];
  logic [3:0] rom_addr;
  logic [7:0] rom_q;
  logic       busy;
  assign a0.req_valid = v[0];
  assign a1.req_valid = v[1];
  assign a0.req_addr  = ad[0];
  assign a1.req_addr  = ad[1];
  assign a0.rsp_ready = rrdy[0];
  assign a1.rsp_ready = rrdy[1];
  assign qrdy = {a1.req_ready, a0.req_ready};
  assign svld = {a1.rsp_valid, a0.rsp_valid};
  assign sdat[0] = a0.rsp_data;
  assign sdat[1] = a1.rsp_data;
  always @(posedge clk) rom_q <= rom_val(int'(rom_addr));
  rom_lookup_arbiter #(.ADDR_W(4), .DATA_W(8), .ROM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .p0(a0), .p1(a1),
    .rom_addr(rom_addr), .rom_data(rom_q), .busy(busy)
  );
  logic       bv = 0;
  logic [3:0] bad = 0;
  logic [3:0] b_rom_addr;
  logic [7:0] bd1, bd2, bd3;
  logic       b_busy;
  assign b0.req_valid = bv;
  assign b0.req_addr  = bad;
  assign b0.rsp_ready = 1'b1;
  assign b1.req_valid = 1'b0;
  assign b1.req_addr  = '0;
  assign b1.rsp_ready = 1'b1;
  always @(posedge clk) begin
    bd1 <= rom_val(int'(b_rom_addr));
    bd2 <= bd1;
    bd3 <= bd2;
  end
  rom_lookup_arbiter #(.ADDR_W(4), .DATA_W(8), .ROM_LAT(3)) dut_lat3 (
    .clk(clk), .rst_n(rst_n), .p0(b0), .p1(b1),
    .rom_addr(b_rom_addr), .rom_data(bd3), .busy(b_busy)
  );
  // Reference model: one outstanding lookup, round-robin pointer, last data per port
  logic [7:0] exq_d [$];
  int         exq_p [$];
  int         gq [$];
  int         gc [$];
  logic       inflight = 0;
  logic       rr_m = 0;
  logic [3:0] cur_addr = 0;
  logic [7:0] last_d [2];
  logic [1:0] prev_sv = 0;
  int         e0 = 0;
  always @(negedge clk) begin
    logic [1:0] exp_r;
    logic [1:0] hs;
    int         pg;
    if (!rst_n) begin
      exq_d.delete();
      exq_p.delete();
      inflight = 0;
      rr_m = 0;
      last_d[0] = 0;
      last_d[1] = 0;
      prev_sv = 0;
    end else begin
      chk("busy", int'(busy), int'(inflight));
      exp_r = 2'b00;
      if (!inflight && v != 0) exp_r = ((v == 2'b11) ? rr_m : v[1]) ? 2'b10 : 2'b01;
      chk("req_ready", int'(qrdy), int'(exp_r));
      if (inflight) chk("rom_addr_hold", int'(rom_addr), int'(cur_addr));
      for (int p = 0; p < 2; p++) begin
        if (svld[p]) begin
          if (exq_d.size() == 0 || exq_p[0] != p) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected port %0d actual valid=1 required valid=0", p);
          end else begin
            chk("rsp_data", int'(sdat[p]), int'(exq_d[0]));
            if (!prev_sv[p]) chk("rsp_latency", cyc - e0, LAT + 1);
            if (rrdy[p]) begin
              last_d[p] = exq_d.pop_front();
              void'(exq_p.pop_front());
              inflight = 0;
              rr_m = (p == 0);
            end
          end
        end else chk("rsp_data_hold", int'(sdat[p]), int'(last_d[p]));
      end
      hs = v & qrdy;
      if (hs != 0) begin
        pg = hs[1] ? 1 : 0;
        exq_d.push_back(rom_val(int'(ad[pg])));
        exq_p.push_back(pg);
        inflight = 1;
        cur_addr = ad[pg];
        e0 = cyc + 1;
        gq.push_back(pg);
        gc.push_back(cyc + 1);
      end
      prev_sv = svld;
    end
  end
  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready"}, int'(qrdy), 0);
    chk({tag, "_valid"}, int'(svld), 0);
    chk({tag, "_rom_addr"}, int'(rom_addr), 0);
    chk({tag, "_data0"}, int'(sdat[0]), 0);
    chk({tag, "_data1"}, int'(sdat[1]), 0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic req(input int p, input logic [3:0] a);
    int n = 0;
    v[p] = 1;
    ad[p] = a;
    do begin
      @(negedge clk);
      n++;
    end while (!qrdy[p] && n < 50);
    if (!qrdy[p]) chk("grant_timeout", 0, 1);
    @(posedge clk);
    #1 v[p] = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 60);
    if (busy) chk("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    logic [1:0] hs2;
    ad[0] = 0;
    ad[1] = 0;
    do_reset();
    req(0, 4'd5);
    wait_idle();
    chk("single_data", int'(sdat[0]), 41);
    v = 2'b11;
    ad[0] = 4'd2;
    ad[1] = 4'd13;
    do_reset();
    gq.delete();
    gc.delete();
    n = 0;
    while (gq.size() < 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 v = 0;
    wait_idle();
    chk("rr_grants", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_order", gq[i], i % 2);
    for (int i = 1; i < 4 && i < gc.size(); i++) chk("rr_period", gc[i] - gc[i-1], 4);
    gq.delete();
    req(1, 4'd6);
    wait_idle();
    req(1, 4'd11);
    wait_idle();
    chk("req1_only_count", gq.size(), 2);
    for (int i = 0; i < gq.size(); i++) chk("req1_only_grant", gq[i], 1);
    rrdy[0] = 0;
    req(0, 4'd7);
    v[1] = 1;
    ad[1] = 4'd2;
    n = 0;
    while (!svld[0] && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("bp_valid", int'(svld[0]), 1);
    repeat (6) @(posedge clk);
    #1 chk("bp_data", int'(sdat[0]), int'(rom_val(7)));
    ad[1] = 4'd9;
    rrdy[0] = 1;
    req(1, 4'd9);
    wait_idle();
    chk("bp_next_data", int'(sdat[1]), int'(rom_val(9)));
    req(1, 4'd3);
    wait_idle();
    req(0, 4'd0);
    wait_idle();
    chk("addr0", int'(sdat[0]), 32);
    req(0, 4'd15);
    wait_idle();
    chk("addr15", int'(sdat[0]), 59);
    chk("other_port_hold", int'(sdat[1]), 37);
    req(0, 4'd9);
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk_zero("midwait");
    @(posedge clk);
    #1 rst_n = 1;
    repeat (8) @(posedge clk);
    #1 chk("no_rsp_after_reset", int'(svld), 0);
    req(0, 4'd4);
    wait_idle();
    chk("post_reset_data", int'(sdat[0]), 39);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hs2 = v & qrdy;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (hs2[p] || (v[p] && $urandom_range(7) == 0)) v[p] = 0;
        else if (!v[p] && $urandom_range(2) == 0) begin
          v[p] = 1;
          ad[p] = 4'($urandom);
        end else if (!v[p]) ad[p] = 4'($urandom);
        rrdy[p] = 1'($urandom_range(1));
      end
    end
    v = 0;
    rrdy = 2'b11;
    wait_idle();
    chk("drain", exq_d.size(), 0);
    bv = 1;
    bad = 4'd10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b0.req_ready && n < 20);
    chk("lat3_grant", int'(b0.req_ready), 1);
    @(posedge clk);
    #1 bv = 0;
    n = 0;
    while (!b0.rsp_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("lat3_latency", n, 4);
    chk("lat3_data", int'(b0.rsp_data), 50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
